// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores into the 16-byte register window push bytes into a small TX FIFO.
// A serializer drains the FIFO onto o_tx, least significant bit first.
`timescale 1ns/1ps
module dmem_uart_tx #(
  parameter int                           P_DATA_WIDTH      = 32,
  parameter int                           P_DMEM_ADDR_WIDTH = 11,
  parameter logic [P_DMEM_ADDR_WIDTH-1:0] P_BASE_ADDR       = 11'h7F0,
  parameter int                           P_FIFO_DEPTH      = 4,
  parameter logic [15:0]                  P_BAUD_DIV_RST    = 16'd433
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_wdata,
  input  logic [2:0]                   i_f3,
  output logic                         o_hit,
  output logic [P_DATA_WIDTH-1:0]      o_rdata,
  output logic                         o_tx,
  output logic                         o_busy
);

  localparam int AW = P_DMEM_ADDR_WIDTH;
  localparam int PW = $clog2(P_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Register window decode
  logic [1:0]    reg_idx;
  logic          wr_en;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic          bit_end;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [P_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    head;

  // Control registers
  logic          overflow;
  logic [15:0]   baud_div;

  // Serializer
  state_t        state;
  logic [15:0]   bit_cnt;
  logic [15:0]   baud_lat;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          tx_q;

  // Byte-lane address bits and upper store data carry no meaning here.
  logic          unused_bits;
  assign unused_bits = ^{i_addr[1:0], i_wdata[P_DATA_WIDTH-1:16]};

  assign o_hit   = (i_addr[AW-1:4] == P_BASE_ADDR[AW-1:4]);
  assign reg_idx = i_addr[3:2];
  assign wr_en   = i_we & o_hit;
  assign push    = wr_en && (reg_idx == 2'd0);

  assign empty   = (count == '0);
  assign full    = (count == CW'(P_FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign bit_end = (bit_cnt == 16'd0);

  // The serializer takes a byte when idle, or at the very end of a stop bit.
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push_ok = push && (!full || pop);

  assign o_tx    = tx_q;
  assign o_busy  = (state != S_IDLE) || !empty;

  // FIFO pointers, occupancy and the sticky overflow flag
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (wr_en && (reg_idx == 2'd1) && i_wdata[3])
        overflow <= 1'b0;
    end
  end

  // FIFO data storage
  // NOTE: the data array is deliberately not reset; count/pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_wdata[7:0];
  end

  // BAUDDIV register; a byte store only replaces the low byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_div <= P_BAUD_DIV_RST;
    end else if (wr_en && (reg_idx == 2'd2)) begin
      if (i_f3 == 3'b000) baud_div[7:0] <= i_wdata[7:0];
      else                baud_div      <= i_wdata[15:0];
    end
  end

  // Read mux, zero outside the window and for write-only/reserved slots
  // NOTE: o_rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_rdata = '0;
    if (o_hit) begin
      case (reg_idx)
        2'd1:    o_rdata = P_DATA_WIDTH'({4'(count), overflow, o_busy, empty, full});
        2'd2:    o_rdata = P_DATA_WIDTH'(baud_div);
        default: o_rdata = '0;
      endcase
    end
  end

  // Frame serializer; o_tx is registered and trails the state by one clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      bit_cnt  <= '0;
      baud_lat <= '0;
      shift    <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift    <= head;
            bit_cnt  <= baud_div;
            baud_lat <= baud_div;
            state    <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bit_cnt <= baud_lat;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          tx_q <= shift[0];
          if (bit_end) begin
            bit_cnt <= baud_lat;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state   <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (pop) begin
              shift    <= head;
              bit_cnt  <= baud_div;
              baud_lat <= baud_div;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
